digital_pattern_handler: RTL and testbench

//   8-channel digital pattern generator: the output-side counterpart of the logic capture path.

---
 rtl/digital_pattern_handler_pkg.sv | 22 ++
 rtl/digital_pattern_handler_ram.sv | 31 +++
 rtl/digital_pattern_handler.sv | 209 ++++++++++++++++++++
 tb/tb_digital_pattern_handler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_pattern_handler_pkg.sv
// rtl/digital_pattern_handler_pkg.sv - shared command codes, defaults and state type for the pattern generator
package digital_pattern_handler_pkg;

    // Command codes on the shared dispatcher bus; capture path owns 0x0B/0x0C
    localparam logic [7:0] DP_LOAD  = 8'h0D;
    localparam logic [7:0] DP_START = 8'h0E;
    localparam logic [7:0] DP_STOP  = 8'h0F;

    // Bit of the START mode byte that selects loop playback
    localparam int MODE_LOOP = 0;

    // 60 MHz / 60 = 1 MS/s after reset
    localparam int DEFAULT_DIV = 60;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX_LOAD  = 2'd1,
        ST_RX_START = 2'd2,
        ST_PLAYING  = 2'd3
    } dp_state_e;

endpackage

// File: rtl/digital_pattern_handler_ram.sv
// rtl/digital_pattern_handler_ram.sv - simple dual-port pattern buffer, synchronous read
module dp_pattern_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port: pattern bytes from the load command
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered data doubles as the sample holding register
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/digital_pattern_handler.sv
// rtl/digital_pattern_handler.sv - 8-channel pattern generator: load, start, stop and replay at a programmable rate
module digital_pattern_handler
    import digital_pattern_handler_pkg::*;
#(
    parameter int         PAT_DEPTH   = 2048,
    parameter int         DEF_DIV     = DEFAULT_DIV,
    parameter logic [7:0] IDLE_LEVEL  = 8'h00,
    localparam int        AW          = $clog2(PAT_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cmd_type,
    input  logic [15:0]   cmd_length,
    input  logic [7:0]    cmd_data,
    input  logic [15:0]   cmd_data_index,
    input  logic          cmd_start,
    input  logic          cmd_data_valid,
    input  logic          cmd_done,
    output logic          cmd_ready,
    output logic [7:0]    dp_signal_out,
    output logic          dp_busy,
    output logic          dp_done,
    output logic [AW:0]   dp_pattern_len
);

    dp_state_e   state_q, state_d;

    logic [7:0]  stage_hi_q, stage_lo_q, stage_mode_q;
    logic [15:0] div_q;
    logic        loop_q;
    logic [AW:0] len_q;
    logic [15:0] cnt_q;
    logic [AW-1:0] ptr_q;
    logic        fin_q;
    logic        out_valid_q;
    logic        done_q;

    logic        ram_wr_en, ram_rd_en;
    logic [7:0]  ram_rd_data;
    logic        load_len, clr_stage, latch_params, begin_play, oneshot_end, leave_play;

    logic        idx_in_range;
    logic [7:0]  hi_eff, lo_eff, mode_eff;
    logic [15:0] div_raw;
    logic        ptr_last;

    assign idx_in_range = cmd_data_index < 16'(PAT_DEPTH);
    assign ptr_last     = ({1'b0, ptr_q} == (len_q - 1'b1));

    // Staged START bytes, including one arriving together with cmd_done
    assign hi_eff   = (cmd_data_valid && cmd_data_index == 16'd0) ? cmd_data : stage_hi_q;
    assign lo_eff   = (cmd_data_valid && cmd_data_index == 16'd1) ? cmd_data : stage_lo_q;
    assign mode_eff = (cmd_data_valid && cmd_data_index == 16'd2) ? cmd_data : stage_mode_q;
    assign div_raw  = {hi_eff, lo_eff};

    dp_pattern_ram #(
        .DEPTH (PAT_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (cmd_data_index[AW-1:0]),
        .wr_data (cmd_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ptr_q),
        .rd_data (ram_rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; a one-shot end outranks a same-cycle command
    always_comb begin
        state_d      = state_q;
        ram_wr_en    = 1'b0;
        ram_rd_en    = 1'b0;
        load_len     = 1'b0;
        clr_stage    = 1'b0;
        latch_params = 1'b0;
        begin_play   = 1'b0;
        oneshot_end  = 1'b0;
        leave_play   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start && cmd_type == DP_LOAD) begin
                    state_d = ST_RX_LOAD;
                end else if (cmd_start && cmd_type == DP_START) begin
                    state_d   = ST_RX_START;
                    clr_stage = 1'b1;
                end
            end
            ST_RX_LOAD: begin
                ram_wr_en = cmd_data_valid && idx_in_range;
                if (cmd_done) begin
                    load_len = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RX_START: begin
                if (cmd_done) begin
                    latch_params = 1'b1;
                    if (len_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        begin_play = 1'b1;
                        state_d    = ST_PLAYING;
                    end
                end
            end
            ST_PLAYING: begin
                if (cnt_q == 16'd0 && fin_q) begin
                    oneshot_end = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cmd_start && cmd_type == DP_STOP) begin
                    leave_play = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cmd_start && cmd_type == DP_START) begin
                    leave_play = 1'b1;
                    clr_stage  = 1'b1;
                    state_d    = ST_RX_START;
                end else if (cnt_q == 16'd0) begin
                    ram_rd_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // START payload staging; missing bytes stay zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_hi_q   <= 8'h00;
            stage_lo_q   <= 8'h00;
            stage_mode_q <= 8'h00;
        end else if (clr_stage) begin
            stage_hi_q   <= 8'h00;
            stage_lo_q   <= 8'h00;
            stage_mode_q <= 8'h00;
        end else if (state_q == ST_RX_START) begin
            stage_hi_q   <= hi_eff;
            stage_lo_q   <= lo_eff;
            stage_mode_q <= mode_eff;
        end
    end

    // Playback parameters and buffer length; a zero divider runs as divide-by-one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 16'(DEF_DIV);
            loop_q <= 1'b0;
            len_q  <= '0;
        end else begin
            if (latch_params) begin
                div_q  <= (div_raw == 16'd0) ? 16'd1 : div_raw;
                loop_q <= mode_eff[MODE_LOOP];
            end
            if (load_len) begin
                len_q <= (cmd_length > 16'(PAT_DEPTH)) ? (AW+1)'(PAT_DEPTH) : cmd_length[AW:0];
            end
        end
    end

    // Sample divider and read pointer; pointer wraps at the loaded length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
            ptr_q <= '0;
            fin_q <= 1'b0;
        end else if (begin_play) begin
            cnt_q <= 16'd0;
            ptr_q <= '0;
            fin_q <= 1'b0;
        end else if (state_q == ST_PLAYING) begin
            cnt_q <= (cnt_q == div_q - 16'd1) ? 16'd0 : cnt_q + 16'd1;
            if (ram_rd_en) begin
                ptr_q <= ptr_last ? '0 : ptr_q + 1'b1;
                fin_q <= !loop_q && ptr_last;
            end
        end
    end

    // Output gating and completion pulse; reset forces the idle level immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= oneshot_end;
            if (oneshot_end || leave_play) begin
                out_valid_q <= 1'b0;
            end else if (ram_rd_en) begin
                out_valid_q <= 1'b1;
            end
        end
    end

    assign dp_signal_out  = out_valid_q ? ram_rd_data : IDLE_LEVEL;
    assign dp_busy        = (state_q == ST_PLAYING);
    assign cmd_ready      = (state_q != ST_PLAYING);
    assign dp_done        = done_q;
    assign dp_pattern_len = len_q;

endmodule

// File: tb/tb_digital_pattern_handler.sv
// tb/tb_digital_pattern_handler.sv - scoreboard bench for the pattern generator against a timeline model
module tb_digital_pattern_handler;
    import digital_pattern_handler_pkg::*;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_type = 8'h00;
    logic [15:0] cmd_length = 16'h0;
    logic [7:0]  cmd_data = 8'h00;
    logic [15:0] cmd_data_index = 16'h0;
    logic        cmd_start = 1'b0;
    logic        cmd_data_valid = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_ready;
    logic [7:0]  dp_signal_out;
    logic        dp_busy;
    logic        dp_done;
    logic [11:0] dp_pattern_len;

    digital_pattern_handler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_type       (cmd_type),
        .cmd_length     (cmd_length),
        .cmd_data       (cmd_data),
        .cmd_data_index (cmd_data_index),
        .cmd_start      (cmd_start),
        .cmd_data_valid (cmd_data_valid),
        .cmd_done       (cmd_done),
        .cmd_ready      (cmd_ready),
        .dp_signal_out  (dp_signal_out),
        .dp_busy        (dp_busy),
        .dp_done        (dp_done),
        .dp_pattern_len (dp_pattern_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [7:0]  out;
        logic        done;
        logic        busy;
        logic [11:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_mem [DEPTH];
    int         m_len = 0;
    int         m_div = DEFAULT_DIV;
    bit         m_loop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: compares whatever expectation is due at this sample point
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
            chk("missed_label", exp_q[0].stamp, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dp_signal_out", dp_signal_out, e.out);
            chk("dp_done", dp_done, e.done);
            chk("dp_busy", dp_busy, e.busy);
            chk("cmd_ready", cmd_ready, !e.busy);
            chk("dp_pattern_len", dp_pattern_len, e.len);
        end
    end

    function automatic exp_t mk_idle(input int t, input bit busy);
        exp_t e;
        e.stamp = t; e.out = 8'h00; e.done = 1'b0; e.busy = busy; e.len = 12'(m_len);
        return e;
    endfunction

    // Expected output at 'rel' cycles after the cmd_done edge: sample k occupies rel in [1+k*div, k*div+div]
    function automatic exp_t play_exp(input int t, input int rel);
        exp_t e;
        int k;
        e = mk_idle(t, 1'b0);
        if (m_len == 0) return e;
        k = (rel - 1) / m_div;
        if (m_loop) begin
            e.out = m_mem[k % m_len];
            e.busy = 1'b1;
        end else if (k < m_len) begin
            e.out = m_mem[k];
            e.busy = 1'b1;
        end else if (rel - 1 == m_len * m_div) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic wait_until(input int label);
        while (cyc < label) @(negedge clk);
    endtask

    // Drives one command starting at the current negedge; returns at the negedge after cmd_done is sampled
    task automatic send_cmd(input logic [7:0] ty, input logic [15:0] length,
                            input logic [7:0] pl[$], input bit coinc);
        cmd_start = 1'b1; cmd_type = ty; cmd_length = length;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < pl.size(); i++) begin
            cmd_data_valid = 1'b1; cmd_data = pl[i]; cmd_data_index = 16'(i);
            cmd_done = coinc && (i == pl.size() - 1);
            @(negedge clk);
        end
        cmd_data_valid = 1'b0;
        if (!(coinc && pl.size() > 0)) begin
            cmd_done = 1'b1;
            @(negedge clk);
        end
        cmd_done = 1'b0;
    endtask

    function automatic int done_label(input int s, input int n, input bit coinc);
        return s + n + ((coinc && n > 0) ? 0 : 1) + 1;
    endfunction

    task automatic do_load(input logic [7:0] pl[$], input bit coinc);
        int s, pd;
        s = cyc;
        pd = done_label(s, pl.size(), coinc);
        for (int t = s + 1; t < pd; t++) exp_q.push_back(mk_idle(t, 1'b0));
        for (int i = 0; i < pl.size(); i++) if (i < DEPTH) m_mem[i] = pl[i];
        m_len = (pl.size() > DEPTH) ? DEPTH : pl.size();
        exp_q.push_back(mk_idle(pd, 1'b0));
        send_cmd(DP_LOAD, 16'(pl.size()), pl, coinc);
    endtask

    task automatic do_start(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] md,
                            input int nb, input bit coinc, input int watch, input bit inject_load);
        logic [7:0] pl[$];
        logic [7:0] junk[$];
        logic [7:0] hv, lv, mv;
        int s, pd;
        s = cyc;
        pd = done_label(s, nb, coinc);
        hv = (nb >= 1) ? hi : 8'h00;
        lv = (nb >= 2) ? lo : 8'h00;
        mv = (nb >= 3) ? md : 8'h00;
        if (nb >= 1) pl.push_back(hi);
        if (nb >= 2) pl.push_back(lo);
        if (nb >= 3) pl.push_back(md);
        m_div = ({hv, lv} == 16'd0) ? 1 : int'({hv, lv});
        m_loop = mv[MODE_LOOP];
        for (int t = s + 1; t < pd; t++) exp_q.push_back(mk_idle(t, 1'b0));
        exp_q.push_back(mk_idle(pd, m_len != 0));
        for (int t = pd + 1; t <= pd + watch; t++) exp_q.push_back(play_exp(t, t - pd));
        send_cmd(DP_START, 16'(nb), pl, coinc);
        if (inject_load) begin
            for (int i = 0; i < 6; i++) junk.push_back(8'($urandom));
            send_cmd(DP_LOAD, 16'd6, junk, 1'b1);
        end
        wait_until(pd + watch);
    endtask

    task automatic do_stop();
        logic [7:0] none[$];
        int s;
        s = cyc;
        for (int t = s + 1; t <= s + 3; t++) exp_q.push_back(mk_idle(t, 1'b0));
        send_cmd(DP_STOP, 16'd0, none, 1'b0);
        wait_until(s + 3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pl[$];
        int n, dv;
        bit lp, cc;

        repeat (3) @(negedge clk);
        chk("reset_out", dp_signal_out, 8'h00);
        chk("reset_busy", dp_busy, 1'b0);
        chk("reset_done", dp_done, 1'b0);
        chk("reset_len", dp_pattern_len, 12'd0);
        chk("reset_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        exp_q.push_back(mk_idle(cyc + 1, 1'b0));
        @(negedge clk);

        // START with an empty buffer never plays
        do_start(8'h00, 8'h03, 8'h00, 3, 1'b0, 4, 1'b0);

        // Walking-one pattern, one-shot at divide-by-3
        pl = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_load(pl, 1'b1);
        do_start(8'h00, 8'h03, 8'h00, 3, 1'b0, 4 * 3 + 3, 1'b0);

        // Same pattern looped every cycle, then STOP
        do_start(8'h00, 8'h01, 8'h01, 3, 1'b1, 11, 1'b0);
        do_stop();

        // Oversized load clamps to the buffer depth; loop wraps at 2048
        pl.delete();
        for (int i = 0; i < 2100; i++) pl.push_back(8'($urandom));
        do_load(pl, 1'b0);
        do_start(8'h00, 8'h00, 8'h01, 3, 1'b0, DEPTH + 10, 1'b0);
        do_stop();

        // Zero divider runs at one sample per cycle
        do_start(8'h00, 8'h00, 8'h00, 3, 1'b0, DEPTH + 3, 1'b0);

        // div_lo arriving with cmd_done, mode byte absent
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
        do_load(pl, 1'b0);
        do_start(8'h00, 8'h04, 8'h01, 2, 1'b1, 5 * 4 + 3, 1'b0);

        // Restart mid-playback with new parameters; a LOAD while playing is ignored
        do_start(8'h00, 8'h02, 8'h01, 3, 1'b0, 7, 1'b0);
        do_start(8'h00, 8'h05, 8'h01, 3, 1'b0, 40, 1'b1);
        do_stop();
        do_start(8'h00, 8'h01, 8'h00, 3, 1'b1, 5 + 3, 1'b0);

        // Randomized load/start rounds
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            cc = 1'($urandom);
            do_load(pl, cc);
            dv = $urandom_range(0, 4);
            lp = 1'($urandom);
            cc = 1'($urandom);
            if (lp) begin
                do_start(8'h00, 8'(dv), 8'h01, 3, cc, $urandom_range(10, 30), 1'b0);
                do_stop();
            end else begin
                do_start(8'h00, 8'(dv), 8'h00, 3, cc, n * ((dv == 0) ? 1 : dv) + 3, 1'b0);
            end
        end

        // Reset in the middle of a looped playback of non-zero bytes
        pl = '{8'h11, 8'h23, 8'h45, 8'h87};
        do_load(pl, 1'b1);
        do_start(8'h00, 8'h02, 8'h01, 3, 1'b0, 7, 1'b0);
        chk("pre_reset_playing", dp_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", dp_signal_out, 8'h00);
        chk("async_reset_busy", dp_busy, 1'b0);
        chk("async_reset_len", dp_pattern_len, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
